// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared processor types and constants for the fetch stage
package fetch_stage_pkg;

  // Fetch FSM: RUN fetches words, HALT is entered once PC leaves instruction memory
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Instruction word inserted into IF/ID when a bubble is created
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter register with next-PC select
module pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en_i,
  input  logic        advance_en_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: a redirect wins, otherwise step by one word or hold
  always_comb begin
    pc_d = pc_q;
    if (redirect_en_i) begin
      pc_d = redirect_target_i;
    end else if (advance_en_i) begin
      pc_d = pc_q + 32'd1;
    end
  end

  // PC storage, cleared to word 0 on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and halt FSM
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MEM_SIZE  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc;
  logic         pc_in_range;
  logic         redirect_en;
  logic         advance_en;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  pc_reg u_pc_reg (
    .clk               (clk),
    .rst               (rst),
    .redirect_en_i     (redirect_en),
    .advance_en_i      (advance_en),
    .redirect_target_i (redirect_target),
    .pc_o              (pc)
  );

  assign pc_in_range = (pc < MEM_LIMIT);
  assign instr_addr  = pc + BASE_ADDR;

  // Next state, PC control and IF/ID update; range check outranks redirect,
  // redirect outranks flush, flush outranks stall
  always_comb begin
    state_d       = state_q;
    redirect_en   = 1'b0;
    advance_en    = 1'b0;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_RUN: begin
        if (!pc_in_range) begin
          state_d       = ST_HALT;
          if_id_pc_d    = 32'd0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (redirect_valid) begin
          redirect_en   = 1'b1;
          if_id_pc_d    = 32'd0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (flush) begin
          advance_en    = !stall;
          if_id_pc_d    = 32'd0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (!stall) begin
          advance_en    = 1'b1;
          if_id_pc_d    = pc;
          if_id_instr_d = instr_in;
          if_id_valid_d = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_HALT: begin
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and IF/ID registers; reset discards any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_count = fetch_count_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, word offset added to PC when driving the instruction memory address.
REQ-002 SHALL have parameter MEM_SIZE, default 16, number of valid instruction words; legal PC range is 0..MEM_SIZE-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stall  input  1  hold PC and IF/ID register.
REQ-006 flush  input  1  squash IF/ID contents (insert bubble).
REQ-007 redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 redirect_target  input  32  word address of next PC when redirect_valid=1.
REQ-009 instr_addr  output  32  address to instruction memory, combinational = PC + BASE_ADDR.
REQ-010 instr_in  input  32  instruction word returned combinationally by memory for instr_addr.
REQ-011 if_id_pc  output  32  PC of the registered instruction.
REQ-012 if_id_instr  output  32  registered instruction word.
REQ-013 if_id_valid  output  1  registered instruction is real (not a bubble).
REQ-014 halted  output  1  fetch stopped because PC left legal range; sticky.
REQ-015 fetch_count  output  32  number of instructions delivered with if_id_valid=1 since reset.

Function
REQ-016 SHALL implement two states: RUN, HALT; reset enters RUN.
REQ-017 In RUN, no stall, no redirect: PC <= PC+1 each cycle (word addressing).
REQ-018 redirect_valid=1 SHALL load PC <= redirect_target next edge, overriding stall.
REQ-019 stall=1 without redirect SHALL hold PC, if_id_pc, if_id_instr, if_id_valid, fetch_count.
REQ-020 flush=1 or redirect_valid=1 SHALL next edge set if_id_valid=0, if_id_instr=32'h0 (NOP), if_id_pc=0; flush beats stall.
REQ-021 Otherwise in RUN, not stalled: if_id_pc<=PC, if_id_instr<=instr_in, if_id_valid<=1, fetch_count<=fetch_count+1.
REQ-022 Latency: instruction at PC appears on if_id_* exactly one edge after PC is presented.
REQ-023 When PC >= MEM_SIZE at a clock edge in RUN (sequential overflow or out-of-range redirect target), SHALL transition to HALT; that word is not captured (if_id_valid<=0).
REQ-024 In HALT: halted=1, PC frozen, if_id_valid=0, fetch_count frozen; stall/flush/redirect ignored; only rst exits.
REQ-025 PC arithmetic is 32-bit unsigned modulo 2^32; fetch_count wraps from 32'hFFFFFFFF to 0.
REQ-026 Simultaneous stall+flush+redirect: PC<=redirect_target, IF/ID bubble.

Reset
REQ-027 rst=1 SHALL asynchronously force PC=0, state=RUN, if_id_pc=0, if_id_instr=0, if_id_valid=0, halted=0, fetch_count=0.
REQ-028 Reset mid-operation (including in HALT) SHALL discard in-flight instruction; first valid fetch is word 0 one edge after rst deasserts.

Structure
REQ-029 State encoding (RUN, HALT) and NOP constant 32'h0 SHALL live in the shared processor package.
REQ-030 PC register with next-PC mux SHALL be a sub-module pc_reg; IF/ID register and FSM stay in fetch_stage.

Verification
REQ-031 Reset release, no stall, memory word k = k+100 -> if_id_instr 100,101,102 on successive edges, if_id_pc 0,1,2, fetch_count 1,2,3.
REQ-032 stall=1 for 3 cycles at PC=4 -> instr_addr stays 4, if_id_* and fetch_count unchanged, resume with PC=5 after release.
REQ-033 redirect_valid=1, target=10 at PC=3 -> next edge if_id_valid=0, PC=10; following edge if_id_pc=10, valid=1.
REQ-034 MEM_SIZE=16, run sequentially -> after PC=15 captured, PC=16 edge sets halted=1, if_id_valid=0, fetch_count=16; later redirect ignored.
REQ-035 Redirect to 20 with MEM_SIZE=16 -> HALT next edge; then rst pulse -> halted=0, PC=0, fetch_count=0 asynchronously.
REQ-036 stall=1, flush=1 together at PC=6 -> if_id_valid=0 next edge, PC holds 6.
